// File: rtl/ahb_master_req_ctrl.sv
// Master-side AHB request/address-phase controller: requests the bus, issues INCR word beats,
// and resumes the remaining beats after a mid-burst grant loss. Flags starvation while waiting.
module ahb_master_req_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [4:0]        cmd_len,
    input  logic              cmd_write,
    input  logic              grant,
    input  logic              hready,
    output logic              req,
    output logic [1:0]        htrans,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic              done,
    output logic              starve
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [7:0] STARVE_TH = 8'(STARVE_LIMIT);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [4:0] clamp_len(input logic [4:0] v);
        return (v > 5'd16) ? 5'd16 : v;
    endfunction

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr, addr_d, addr_inc, addr_aligned, haddr_d;
    logic [4:0]        remaining, remaining_d, rem_dec, len_c;
    logic [7:0]        wait_cnt, wait_cnt_d, wait_inc;
    logic              req_d, hwrite_d, done_d, starve_d;
    logic [1:0]        htrans_d;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^cmd_addr[1:0];
    assign addr_aligned     = {cmd_addr[ADDR_W-1:2], 2'b00};
    assign addr_inc         = addr + ADDR_W'(4);
    assign rem_dec          = remaining - 5'd1;
    assign len_c            = clamp_len(cmd_len);
    assign wait_inc         = sat_inc8(wait_cnt);
    assign cmd_ready        = (state == S_IDLE);

    always_comb begin
        state_d     = state;
        addr_d      = addr;
        remaining_d = remaining;
        wait_cnt_d  = wait_cnt;
        req_d       = req;
        htrans_d    = htrans;
        haddr_d     = haddr;
        hwrite_d    = hwrite;
        done_d      = 1'b0;
        starve_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d      = addr_aligned;
                    remaining_d = len_c;
                    if (len_c != 5'd0) begin
                        state_d    = S_REQ;
                        req_d      = 1'b1;
                        htrans_d   = HT_IDLE;
                        haddr_d    = addr_aligned;
                        hwrite_d   = cmd_write;
                        wait_cnt_d = 8'd0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (grant && hready) begin
                    state_d    = S_XFER;
                    htrans_d   = HT_NONSEQ;
                    haddr_d    = addr;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_inc;
                    starve_d   = (wait_inc >= STARVE_TH);
                end
            end
            S_XFER: begin
                // Grant is only meaningful on edges that accept a beat.
                if (hready) begin
                    remaining_d = rem_dec;
                    addr_d      = addr_inc;
                    if (rem_dec == 5'd0) begin
                        state_d  = S_IDLE;
                        req_d    = 1'b0;
                        htrans_d = HT_IDLE;
                        done_d   = 1'b1;
                    end else if (grant) begin
                        htrans_d = (addr_inc[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
                        haddr_d  = addr_inc;
                    end else begin
                        state_d  = S_REQ;
                        htrans_d = HT_IDLE;
                        haddr_d  = addr_inc;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                req_d    = 1'b0;
                htrans_d = HT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= 5'd0;
            wait_cnt  <= 8'd0;
            req       <= 1'b0;
            htrans    <= HT_IDLE;
            haddr     <= '0;
            hwrite    <= 1'b0;
            done      <= 1'b0;
            starve    <= 1'b0;
        end else begin
            state     <= state_d;
            addr      <= addr_d;
            remaining <= remaining_d;
            wait_cnt  <= wait_cnt_d;
            req       <= req_d;
            htrans    <= htrans_d;
            haddr     <= haddr_d;
            hwrite    <= hwrite_d;
            done      <= done_d;
            starve    <= starve_d;
        end
    end

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Table-driven bench for ahb_master_req_ctrl: per-cycle vectors plus hand-written
// sequences for length clamping, address wrap and asynchronous reset mid-burst.
module tb_ahb_master_req_ctrl;

    localparam int ADDR_W       = 32;
    localparam int STARVE_LIMIT = 8;
    localparam logic [1:0] TI = 2'b00;
    localparam logic [1:0] TN = 2'b10;
    localparam logic [1:0] TS = 2'b11;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [4:0]        cmd_len;
    logic              cmd_write;
    logic              grant;
    logic              hready;
    logic              req;
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic              done;
    logic              starve;

    ahb_master_req_ctrl #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_write(cmd_write),
        .grant(grant), .hready(hready),
        .req(req), .htrans(htrans), .haddr(haddr), .hwrite(hwrite),
        .done(done), .starve(starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        cv;
        logic [31:0] ca;
        logic [4:0]  cl;
        logic        cw;
        logic        g;
        logic        h;
        logic [38:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [38:0] pk(logic rdy, logic rq, logic [1:0] tr, logic [31:0] ha,
                                       logic hw, logic dn, logic st);
        return {rdy, rq, tr, ha, hw, dn, st};
    endfunction

    function automatic vec_t mk(string nm, logic cv, logic [31:0] ca, logic [4:0] cl, logic cw,
                                logic g, logic h, logic [38:0] e);
        vec_t v;
        v.name = nm; v.cv = cv; v.ca = ca; v.cl = cl; v.cw = cw; v.g = g; v.h = h; v.exp = e;
        return v;
    endfunction

    task automatic chk(string nm, logic [38:0] e);
        logic [38:0] a;
        a = {cmd_ready, req, htrans, haddr, hwrite, done, starve};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got rdy=%b req=%b htrans=%b haddr=%h hwrite=%b done=%b starve=%b, need rdy=%b req=%b htrans=%b haddr=%h hwrite=%b done=%b starve=%b",
                     nm, a[38], a[37], a[36:35], a[34:3], a[2], a[1], a[0],
                     e[38], e[37], e[36:35], e[34:3], e[2], e[1], e[0]);
        end
    endtask

    task automatic drive(logic cv, logic [31:0] ca, logic [4:0] cl, logic cw, logic g, logic h);
        cmd_valid = cv; cmd_addr = ca; cmd_len = cl; cmd_write = cw; grant = g; hready = h;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic [31:0] ea;
        // len 4 write burst, fully granted
        tbl.push_back(mk("a_req",   1, 32'h100, 4, 1, 1, 1, pk(0,1,TI,32'h100,1,0,0)));
        tbl.push_back(mk("a_b0",    0, 0, 0, 0, 1, 1, pk(0,1,TN,32'h100,1,0,0)));
        tbl.push_back(mk("a_b1",    0, 0, 0, 0, 1, 1, pk(0,1,TS,32'h104,1,0,0)));
        tbl.push_back(mk("a_b2",    0, 0, 0, 0, 1, 1, pk(0,1,TS,32'h108,1,0,0)));
        tbl.push_back(mk("a_b3",    0, 0, 0, 0, 1, 1, pk(0,1,TS,32'h10C,1,0,0)));
        tbl.push_back(mk("a_done",  0, 0, 0, 0, 1, 1, pk(1,0,TI,32'h10C,1,1,0)));
        tbl.push_back(mk("a_idle",  0, 0, 0, 0, 1, 1, pk(1,0,TI,32'h10C,1,0,0)));
        // starvation with the grant withheld
        tbl.push_back(mk("b_req",   1, 32'h40, 1, 0, 0, 1, pk(0,1,TI,32'h40,0,0,0)));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(mk($sformatf("b_wait%0d", k), 0, 0, 0, 0, 0, 1, pk(0,1,TI,32'h40,0,0,0)));
        tbl.push_back(mk("b_starve8", 0, 0, 0, 0, 0, 1, pk(0,1,TI,32'h40,0,0,1)));
        tbl.push_back(mk("b_starve9", 0, 0, 0, 0, 0, 1, pk(0,1,TI,32'h40,0,0,1)));
        tbl.push_back(mk("b_grant_nordy", 0, 0, 0, 0, 1, 0, pk(0,1,TI,32'h40,0,0,1)));
        tbl.push_back(mk("b_xfer",  0, 0, 0, 0, 1, 1, pk(0,1,TN,32'h40,0,0,0)));
        tbl.push_back(mk("b_done",  0, 0, 0, 0, 1, 1, pk(1,0,TI,32'h40,0,1,0)));
        // grant lost after beat 2, then resume
        tbl.push_back(mk("c_req",   1, 32'h200, 6, 1, 1, 1, pk(0,1,TI,32'h200,1,0,0)));
        tbl.push_back(mk("c_b0",    0, 0, 0, 0, 1, 1, pk(0,1,TN,32'h200,1,0,0)));
        tbl.push_back(mk("c_b1",    0, 0, 0, 0, 1, 1, pk(0,1,TS,32'h204,1,0,0)));
        tbl.push_back(mk("c_lost0", 0, 0, 0, 0, 0, 1, pk(0,1,TI,32'h208,1,0,0)));
        tbl.push_back(mk("c_lost1", 0, 0, 0, 0, 0, 1, pk(0,1,TI,32'h208,1,0,0)));
        tbl.push_back(mk("c_lost2", 0, 0, 0, 0, 0, 1, pk(0,1,TI,32'h208,1,0,0)));
        tbl.push_back(mk("c_res0",  0, 0, 0, 0, 1, 1, pk(0,1,TN,32'h208,1,0,0)));
        tbl.push_back(mk("c_res1",  0, 0, 0, 0, 1, 1, pk(0,1,TS,32'h20C,1,0,0)));
        tbl.push_back(mk("c_res2",  0, 0, 0, 0, 1, 1, pk(0,1,TS,32'h210,1,0,0)));
        tbl.push_back(mk("c_res3",  0, 0, 0, 0, 1, 1, pk(0,1,TS,32'h214,1,0,0)));
        tbl.push_back(mk("c_done",  0, 0, 0, 0, 1, 1, pk(1,0,TI,32'h214,1,1,0)));
        // 1 KB boundary crossing, accepted right after the previous done
        tbl.push_back(mk("d_req",   1, 32'h3F8, 4, 0, 1, 1, pk(0,1,TI,32'h3F8,0,0,0)));
        tbl.push_back(mk("d_b0",    0, 0, 0, 0, 1, 1, pk(0,1,TN,32'h3F8,0,0,0)));
        tbl.push_back(mk("d_b1",    0, 0, 0, 0, 1, 1, pk(0,1,TS,32'h3FC,0,0,0)));
        tbl.push_back(mk("d_b2",    0, 0, 0, 0, 1, 1, pk(0,1,TN,32'h400,0,0,0)));
        tbl.push_back(mk("d_b3",    0, 0, 0, 0, 1, 1, pk(0,1,TS,32'h404,0,0,0)));
        tbl.push_back(mk("d_done",  0, 0, 0, 0, 1, 1, pk(1,0,TI,32'h404,0,1,0)));
        // wait states on beat 2; grant drop and new command during the stall are ignored
        tbl.push_back(mk("e_req",   1, 32'h500, 3, 1, 1, 1, pk(0,1,TI,32'h500,1,0,0)));
        tbl.push_back(mk("e_b0",    0, 0, 0, 0, 1, 1, pk(0,1,TN,32'h500,1,0,0)));
        tbl.push_back(mk("e_b1",    0, 0, 0, 0, 1, 1, pk(0,1,TS,32'h504,1,0,0)));
        tbl.push_back(mk("e_wait0", 1, 32'h900, 2, 0, 0, 0, pk(0,1,TS,32'h504,1,0,0)));
        tbl.push_back(mk("e_wait1", 0, 0, 0, 0, 1, 0, pk(0,1,TS,32'h504,1,0,0)));
        tbl.push_back(mk("e_b2",    0, 0, 0, 0, 1, 1, pk(0,1,TS,32'h508,1,0,0)));
        tbl.push_back(mk("e_done",  0, 0, 0, 0, 1, 1, pk(1,0,TI,32'h508,1,1,0)));
        // zero-length command
        tbl.push_back(mk("f_len0",  1, 32'h600, 0, 0, 1, 1, pk(1,0,TI,32'h508,1,1,0)));
        tbl.push_back(mk("f_after", 0, 0, 0, 0, 1, 1, pk(1,0,TI,32'h508,1,0,0)));

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        chk("reset_state", pk(1,0,TI,32'h0,0,0,0));
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].cv, tbl[i].ca, tbl[i].cl, tbl[i].cw, tbl[i].g, tbl[i].h);
            @(posedge clk);
            #1;
            chk(tbl[i].name, tbl[i].exp);
        end

        // len 31 clamps to 16 beats; misaligned start wraps through address 0
        drive(1, 32'hFFFF_FFFB, 5'd31, 0, 1, 1);
        @(posedge clk); #1;
        chk("g_req", pk(0,1,TI,32'hFFFF_FFF8,0,0,0));
        drive(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 16; k++) begin
            ea = 32'hFFFF_FFF8 + 32'(4 * k);
            @(posedge clk); #1;
            chk($sformatf("g_beat%0d", k),
                pk(0, 1, (k == 0 || ea[9:0] == 10'd0) ? TN : TS, ea, 0, 0, 0));
        end
        @(posedge clk); #1;
        chk("g_done", pk(1,0,TI,32'h34,0,1,0));

        // asynchronous reset during beat 1 of a burst
        drive(1, 32'h700, 3, 1, 1, 1);
        @(posedge clk); #1;
        chk("h_req", pk(0,1,TI,32'h700,1,0,0));
        drive(0, 0, 0, 0, 1, 1);
        @(posedge clk); #1;
        chk("h_b0", pk(0,1,TN,32'h700,1,0,0));
        #2;
        reset = 1'b0;
        #1;
        chk("h_reset_now", pk(1,0,TI,32'h0,0,0,0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("h_idle_after", pk(1,0,TI,32'h0,0,0,0));
        drive(1, 32'h800, 1, 1, 1, 1);
        @(posedge clk); #1;
        chk("h_new_req", pk(0,1,TI,32'h800,1,0,0));
        drive(0, 0, 0, 0, 1, 1);
        @(posedge clk); #1;
        chk("h_new_b0", pk(0,1,TN,32'h800,1,0,0));
        @(posedge clk); #1;
        chk("h_new_done", pk(1,0,TI,32'h800,1,1,0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_master_req_ctrl.md
# ahb_master_req_ctrl

Master-side bus request and address-phase controller for one AHB master port, the initiator counterpart of the team's 4-way lottery arbiter. It accepts a burst command from local logic and raises the bus request (r0..r3 input of the arbiter). Once ownership is granted (grant high with `hready` high), it issues the INCR word-beat address phases. If the arbiter revokes the grant mid-burst, it drops to IDLE, re-requests, and resumes the remaining beats. A wait-cycle counter flags starvation.

## Interface
Parameters:
- ADDR_W, 32, address width
- STARVE_LIMIT, 64, REQ-state cycles before `starve` asserts (1..255)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_addr  in  ADDR_W  burst start address, word-aligned (bits[1:0] ignored, treated as 0)
- cmd_len  in  5  beat count 0..16 (17..31 clamped to 16)
- cmd_write  in  1  1 = write burst
- grant  in  1  arbiter grant for this master
- hready  in  1  bus ready
- req  out  1  bus request to arbiter
- htrans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ
- haddr  out  ADDR_W  address phase
- hwrite  out  1  direction of current burst
- done  out  1  one-cycle pulse after the final beat's address phase is accepted
- starve  out  1  request pending ≥ STARVE_LIMIT cycles

## Operation
- States: IDLE, REQ, XFER. Registers: addr, remaining (5b), wait_cnt (8b), all outputs except `cmd_ready` (decoded from state).
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch addr/len/write.
  - len≠0 → REQ.
  - len=0 → stay IDLE and pulse `done` next cycle; `req` never rises.
- REQ:
  - `req`=1, `htrans`=IDLE.
  - wait_cnt increments each cycle, saturating at 255.
  - At an edge where `grant`=1 and `hready`=1 → XFER, with `htrans`=NONSEQ, `haddr`=addr, and wait_cnt cleared.
- XFER:
  - `req`=1.
  - Edges where `hready`=0: hold every output.
  - Edge where `hready`=1 (beat accepted): remaining−1, addr+4.
    - remaining reaches 0 → IDLE: `req`=0, `htrans`=IDLE, `done`=1 for one cycle.
    - Else if `grant`=1 → next beat. `htrans`=SEQ, except NONSEQ when the new addr[9:0]==0 (1 KB boundary).
    - Else (grant lost) → REQ: `htrans`=IDLE, `haddr` holds the next address, remaining is preserved. Re-entry to XFER starts with NONSEQ.
- `starve` = (wait_cnt ≥ STARVE_LIMIT) while in REQ; otherwise 0.
- Address arithmetic: wraps modulo 2^ADDR_W, with no error.

## Timing
- All outputs are registered; `cmd_ready` is decoded from the registered state.
- Reset values: state IDLE, `req`=0, `htrans`=00, `haddr`=0, `hwrite`=0, `done`=0, `starve`=0, `cmd_ready`=1, wait_cnt=0, remaining=0.
- Reset asserted mid-burst: immediate return to reset values, and the command is discarded.
- Latency:
  - `cmd_valid` accepted at edge N → `req`=1 from N+1.
  - Grant sampled (with `hready`) at edge M → first NONSEQ visible from M+1.
- Fully granted L-beat burst with `hready`=1 throughout: L consecutive address-phase cycles, `done` on the cycle after the last, `req` low from that same cycle.
- A grant drop that coincides with an `hready`=0 cycle is ignored; grant is only evaluated on edges where `hready`=1.
- A new command can be accepted on the edge following the `done` pulse (single-cycle IDLE minimum).

## Test plan
- Addr 0x100, len 4, write, grant and `hready` high: NONSEQ 0x100, SEQ 0x104/0x108/0x10C on 4 consecutive cycles. `done` on cycle 5, `req`=0, `hwrite`=1 throughout.
- Grant withheld 10 cycles, STARVE_LIMIT=8: `req` high, `htrans`=IDLE. `starve` rises after 8 REQ cycles and falls when XFER is entered.
- Addr 0x200, len 6, grant dropped after beat 2 accepted for 3 cycles: IDLE with `haddr`=0x208, then resume NONSEQ 0x208, SEQ 0x20C/0x210/0x214, then `done`.
- Addr 0x3F8, len 4: NONSEQ 0x3F8, SEQ 0x3FC, NONSEQ 0x400, SEQ 0x404.
- `hready`=0 for 2 cycles on beat 2 of a len-3 burst: `haddr`/`htrans` held, total 5 address cycles. Then reset asserted on the next burst's beat 1: all outputs 0 and `cmd_ready`=1 immediately.
- len 0 command: `cmd_ready` stays high, `req` never asserts, `done` pulses once the next cycle.
